// File: rtl/fetch_unit.sv
// Instruction fetch: program counter, one outstanding imem request, DEPTH-entry prefetch queue.
// Optional macro FETCH_BYPASS_EN: a response arriving at an empty queue drives Instr in the same cycle.
module fetch_unit #(
  parameter int              ADDR_W   = 16,
  parameter int              DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       Instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] branch_target
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] req_pc_q;
  logic [15:0]       data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic q_empty, rsp, grant, push, pop, byp_valid, byp_take;

  assign q_empty = (cnt_q == '0);
  // A response in the redirect cycle is stale and never reaches the queue or the bypass.
  assign rsp     = (state_q == WAIT) && imem_rvalid && !PCSrc;

`ifdef FETCH_BYPASS_EN
  assign byp_valid = rsp && q_empty;
`else
  assign byp_valid = 1'b0;
`endif

  assign byp_take  = byp_valid && instr_ready;
  assign push      = rsp && !byp_take;
  assign pop       = !q_empty && instr_ready && !PCSrc;
  assign grant     = imem_req && imem_gnt;
  assign imem_addr = fpc_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    if (PCSrc) cnt_d = '0;
  end

  always_comb begin
    fpc_d = fpc_q;
    if (PCSrc)      fpc_d = branch_target & ~ADDR_W'(1);
    else if (grant) fpc_d = fpc_q + ADDR_W'(2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (grant) state_d = WAIT;
      WAIT: begin
        if (PCSrc)            state_d = imem_rvalid ? IDLE : DROP;
        else if (imem_rvalid) state_d = grant ? WAIT : IDLE;
      end
      DROP: if (imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request gated by reset so the port reads 0 while reset is held.
  always_comb begin
    imem_req    = reset && !PCSrc &&
                  ((state_q == IDLE) || ((state_q == WAIT) && imem_rvalid)) &&
                  (cnt_d < CNT_W'(DEPTH));
    instr_valid = !q_empty || byp_valid;
    Instr       = data_q[rd_ptr_q];
    instr_pc    = pc_q[rd_ptr_q];
    if (byp_valid) begin
      Instr    = imem_rdata;
      instr_pc = req_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc_q    <= RESET_PC;
      req_pc_q <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= RESET_PC;
      end
    end else begin
      fpc_q <= fpc_d;
      cnt_q <= cnt_d;
      if (grant) req_pc_q <= fpc_q;
      if (PCSrc) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          data_q[wr_ptr_q] <= imem_rdata;
          pc_q[wr_ptr_q]   <= req_pc_q;
          wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model with configurable latency, expected-instruction queue.
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic [15:0] Instr;
  logic        instr_valid;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        PCSrc;
  logic [15:0] branch_target;

  fetch_unit #(.ADDR_W(16), .DEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .Instr(Instr), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .PCSrc(PCSrc), .branch_target(branch_target)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int lat      = 1;

  logic [15:0] pend_addr[$];
  int          pend_due[$];
  logic [15:0] exp_pc[$];
  logic [15:0] exp_in[$];
  int          cons_cyc[$];

  logic        m_g;
  logic [15:0] m_a, m_pa;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic exp_push(input logic [15:0] pc, input logic [15:0] ins);
    exp_pc.push_back(pc);
    exp_in.push_back(ins);
  endtask

  // Memory: data at byte address a is 16'hA001 + a/2, returned lat cycles after the grant.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    forever begin
      @(negedge clk);
      m_g = reset && imem_req && imem_gnt;
      m_a = imem_addr;
      @(posedge clk);
      #1;
      cyc++;
      if (m_g) begin
        pend_addr.push_back(m_a);
        pend_due.push_back(cyc + lat - 1);
      end
      imem_rvalid = 1'b0;
      if (!reset) begin
        pend_addr.delete();
        pend_due.delete();
      end else if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
        m_pa = pend_addr.pop_front();
        void'(pend_due.pop_front());
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hA001 + {1'b0, m_pa[15:1]};
      end
    end
  end

  // Monitor: every consumed instruction is compared with the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && instr_valid && instr_ready && !PCSrc) begin
        cons_cyc.push_back(cyc);
        if (exp_pc.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_instr: got pc %0h instr %0h, expected nothing", instr_pc, Instr);
        end else begin
          check("instr_pc", {16'h0, instr_pc}, {16'h0, exp_pc.pop_front()});
          check("Instr", {16'h0, Instr}, {16'h0, exp_in.pop_front()});
        end
      end
      if (reset && imem_req) check("single_outstanding", pend_addr.size(), 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic grant_n(input int n);
    int k;
    int b;
    k = 0;
    b = 0;
    @(posedge clk);
    #1 imem_gnt = 1'b1;
    while (k < n && b < 200) begin
      @(negedge clk);
      b++;
      if (imem_req) k++;
    end
    @(posedge clk);
    #1 imem_gnt = 1'b0;
    check("grant_count", k, n);
  endtask

  task automatic wait_empty(input string name);
    int b;
    b = 0;
    while (exp_pc.size() != 0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    check(name, exp_pc.size(), 0);
  endtask

  initial begin
    int b;
    int span;
    reset = 1'b0; imem_gnt = 1'b0; instr_ready = 1'b0;
    PCSrc = 1'b0; branch_target = 16'h0000;

    // Reset values, then fill the queue with the consumer stalled.
    repeat (3) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_instr", Instr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_pc", instr_pc, 0);
    @(posedge clk);
    #1 reset = 1'b1; imem_gnt = 1'b1;
    @(negedge clk);
    check("c0_req", imem_req, 1);
    check("c0_addr", imem_addr, 0);
    check("c0_valid", instr_valid, 0);
    @(negedge clk);
    check("c1_valid", instr_valid, BYP);
    @(negedge clk);
    check("c2_valid", instr_valid, 1);
    check("c2_pc", instr_pc, 0);
    check("c2_instr", Instr, 16'hA001);
    repeat (10) @(negedge clk);
    check("full_req", imem_req, 0);
    check("full_instr", Instr, 16'hA001);
    check("full_pc", instr_pc, 0);
    check("full_valid", instr_valid, 1);
    check("full_fpc", imem_addr, 16'h0004);
    @(posedge clk);
    #1 imem_gnt = 1'b0;
    exp_push(16'h0000, 16'hA001);
    exp_push(16'h0002, 16'hA002);
    instr_ready = 1'b1;
    wait_empty("drain_a");

    // Sustained stream, one instruction per cycle.
    cons_cyc.delete();
    exp_push(16'h0004, 16'hA003);
    exp_push(16'h0006, 16'hA004);
    exp_push(16'h0008, 16'hA005);
    exp_push(16'h000A, 16'hA006);
    exp_push(16'h000C, 16'hA007);
    exp_push(16'h000E, 16'hA008);
    grant_n(6);
    wait_empty("drain_b");
    check("b_cons_count", cons_cyc.size(), 6);
    span = (cons_cyc.size() != 0) ? cons_cyc[cons_cyc.size()-1] - cons_cyc[0] : -1;
    check("b_throughput_span", span, 5);

    // Redirect with a request in flight, 3-cycle memory.
    @(posedge clk);
    #1 instr_ready = 1'b0; lat = 3; imem_gnt = 1'b1;
    b = 0;
    do begin @(negedge clk); b++; end while (!instr_valid && b < 50);
    check("c_fill_valid", instr_valid, 1);
    @(posedge clk);
    #1 PCSrc = 1'b1; branch_target = 16'h0041;
    @(negedge clk);
    check("c_req_forced0", imem_req, 0);
    @(posedge clk);
    #1 PCSrc = 1'b0;
    @(negedge clk);
    check("c_flushed", instr_valid, 0);
    b = 0;
    while (!imem_req && b < 20) begin @(negedge clk); b++; end
    check("c_req_resume", imem_req, 1);
    check("c_target_addr", imem_addr, 16'h0040);
    repeat (15) @(negedge clk);
    check("c_full_req", imem_req, 0);
    check("c_full_pc", instr_pc, 16'h0040);
    check("c_full_instr", Instr, 16'hA021);
    @(posedge clk);
    #1 imem_gnt = 1'b0;
    exp_push(16'h0040, 16'hA021);
    exp_push(16'h0042, 16'hA022);
    instr_ready = 1'b1;
    wait_empty("drain_c");

    // Redirect in the same cycle as a response with the consumer ready.
    grant_n(1);
    b = 0;
    do begin @(posedge clk); #2; b++; end while (!imem_rvalid && b < 20);
    check("d_rvalid_seen", imem_rvalid, 1);
    PCSrc = 1'b1; branch_target = 16'h0080;
    @(negedge clk);
    check("d_req_forced0", imem_req, 0);
    check("d_valid_in_redirect", instr_valid, 0);
    @(posedge clk);
    #1 PCSrc = 1'b0;
    @(negedge clk);
    check("d_valid_after", instr_valid, 0);
    check("d_addr", imem_addr, 16'h0080);
    exp_push(16'h0080, 16'hA041);
    exp_push(16'h0082, 16'hA042);
    grant_n(2);
    wait_empty("drain_d");

    // Reset asserted mid-fetch, then restart from RESET_PC.
    @(posedge clk);
    #1 lat = 1; instr_ready = 1'b0; imem_gnt = 1'b1;
    b = 0;
    do begin @(negedge clk); b++; end while (!imem_req && b < 20);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("f_req", imem_req, 0);
    check("f_addr", imem_addr, 0);
    check("f_valid", instr_valid, 0);
    check("f_instr", Instr, 0);
    check("f_pc", instr_pc, 0);
    imem_gnt = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("f_restart_addr", imem_addr, 0);
    check("f_restart_req", imem_req, 1);
    instr_ready = 1'b1;
    exp_push(16'h0000, 16'hA001);
    exp_push(16'h0002, 16'hA002);
    exp_push(16'h0004, 16'hA003);
    grant_n(3);
    wait_empty("drain_f");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
